// File: rtl/fc_event_fifo.sv
// fc_event_fifo: buffers FC event IDs from the SoC event stream and exposes
// them to software through an APB pop register with a threshold interrupt.
module fc_event_fifo #(
  parameter int unsigned EVNT_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      event_valid_i,
  input  logic [EVNT_WIDTH-1:0]     event_data_i,
  output logic                      event_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] REG_POP    = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_FLUSH  = 3'd3;
  localparam logic [2:0] REG_DROP   = 3'd4;

  logic [EVNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  enable;
  logic                  irq_en;
  logic [7:0]            threshold;
  logic [7:0]            thr_eff;
  logic [15:0]           drop_cnt;
  logic                  irq_next;
  logic [2:0]            reg_sel;
  logic                  access;
  logic                  rd_access;
  logic                  wr_access;
  logic                  empty;
  logic                  full;
  logic                  flush;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [EVNT_WIDTH-1:0] head;
  logic                  unused_bits;

  assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31:16], PWDATA[7:2]};
  assign PREADY      = 1'b1;

  // Access decode, handshake and next-count computation
  always_comb begin
    reg_sel    = PADDR[4:2];
    access     = PSEL & PENABLE;
    rd_access  = access & ~PWRITE;
    wr_access  = access & PWRITE;
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    event_ready_o = ~enable | ~full;
    flush      = wr_access & (reg_sel == REG_FLUSH) & PWDATA[0];
    pop        = rd_access & (reg_sel == REG_POP) & ~empty;
    push       = event_valid_i & event_ready_o & enable & ~flush;
    drop       = event_valid_i & event_ready_o & (~enable | flush);
    count_next = flush ? '0 : (count + CW'(push) - CW'(pop));
    thr_eff    = (threshold == 8'd0) ? 8'd1 : threshold;
    irq_next   = irq_en & (8'(count_next) >= thr_eff);
    head       = empty ? '0 : mem[rd_ptr];
  end

  // Read mux, decoded from the address alone so idle reads are defined
  always_comb begin
    PRDATA  = 32'h0;
    PSLVERR = access & (reg_sel > REG_DROP);
    case (reg_sel)
      REG_POP:    PRDATA = {~empty, 7'b0, 8'(count), 16'(head)};
      REG_STATUS: PRDATA = {16'h0, 8'(count), 6'b0, full, empty};
      REG_CTRL:   PRDATA = {16'h0, threshold, 6'b0, irq_en, enable};
      REG_DROP:   PRDATA = {16'h0, drop_cnt};
      default:    PRDATA = 32'h0;
    endcase
  end

  // FIFO pointers, occupancy and interrupt level
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq_o  <= 1'b0;
    end else begin
      count <= count_next;
      irq_o <= irq_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Software control register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable    <= 1'b1;
      irq_en    <= 1'b0;
      threshold <= 8'd1;
    end else if (wr_access && (reg_sel == REG_CTRL)) begin
      enable    <= PWDATA[0];
      irq_en    <= PWDATA[1];
      threshold <= PWDATA[15:8];
    end
  end

  // Saturating count of discarded events; any write clears it
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      drop_cnt <= 16'h0;
    end else if (wr_access && (reg_sel == REG_DROP)) begin
      drop_cnt <= 16'h0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Event storage; contents are only meaningful below count
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= event_data_i;
  end

endmodule

// File: tb/tb_fc_event_fifo.sv
// Testbench for fc_event_fifo: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the event buffer.
module tb_fc_event_fifo;

  localparam int DEPTH = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        ev_valid = 1'b0;
  logic [7:0]  ev_data = 8'h0;
  logic        ev_ready;
  logic [11:0] PADDR = 12'h0;
  logic [31:0] PWDATA = 32'h0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq;

  fc_event_fifo dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .event_valid_i(ev_valid), .event_data_i(ev_data), .event_ready_o(ev_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [7:0]  src_q[$];
  logic        m_en, m_ien, m_irq;
  logic [7:0]  m_thr;
  logic [15:0] m_drop;
  logic [31:0] last_rd;
  logic        last_slverr;
  logic        last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 1'b1; m_ien = 1'b0; m_irq = 1'b0; m_thr = 8'd1; m_drop = 16'h0;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, cross the edge
  task automatic tick();
    logic [31:0] exp_rd;
    logic [7:0]  head;
    logic        rdy, acc, wr, rd, ne, fl, pp, pu, dr, ien_old;
    int          sel, thr_e;
    #4;
    sel  = int'(PADDR[4:2]);
    ne   = (q.size() != 0);
    head = 8'h00;
    if (ne) head = q[0];
    rdy  = !m_en || (q.size() < DEPTH);
    acc  = PSEL && PENABLE;
    case (sel)
      0: exp_rd = {ne, 7'b0, 8'(q.size()), 8'h00, head};
      1: exp_rd = {16'h0, 8'(q.size()), 6'b0, (q.size() == DEPTH), !ne};
      2: exp_rd = {16'h0, m_thr, 6'b0, m_ien, m_en};
      4: exp_rd = {16'h0, m_drop};
      default: exp_rd = 32'h0;
    endcase
    check("ready", 32'(ev_ready), 32'(rdy));
    check("irq", 32'(irq), 32'(m_irq));
    check("prdata", PRDATA, exp_rd);
    check("pslverr", 32'(PSLVERR), 32'(acc && sel >= 5));
    last_rd     = PRDATA;
    last_slverr = PSLVERR;
    last_acc    = ev_valid && rdy;
    wr = acc && PWRITE;
    rd = acc && !PWRITE;
    fl = wr && sel == 3 && PWDATA[0];
    pp = rd && sel == 0 && ne;
    pu = ev_valid && rdy && m_en && !fl;
    dr = ev_valid && rdy && (!m_en || fl);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (pu) q.push_back(ev_data);
    end
    if (wr && sel == 4) m_drop = 16'h0;
    else if (dr && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    ien_old = m_ien;
    thr_e   = (m_thr == 8'd0) ? 1 : int'(m_thr);
    m_irq   = ien_old && (q.size() >= thr_e);
    if (wr && sel == 2) begin
      m_en = PWDATA[0]; m_ien = PWDATA[1]; m_thr = PWDATA[15:8];
    end
    @(posedge HCLK);
    #1;
    if (last_acc) void'(src_q.pop_front());
    ev_valid = (src_q.size() != 0);
    if (ev_valid) ev_data = src_q[0];
  endtask

  task automatic send(input logic [7:0] id);
    src_q.push_back(id);
    ev_valid = 1'b1;
    ev_data  = src_q[0];
  endtask

  task automatic wait_src_empty(input int budget);
    int n;
    n = 0;
    while (src_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("src_drain", 32'(src_q.size()), 32'h0);
  endtask

  // APB transfer; pid[8] offers event pid[7:0] in the access phase
  task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic [8:0] pid, output logic [31:0] r);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    tick();
    if (pid[8]) send(pid[7:0]);
    PENABLE = 1'b1;
    tick();
    r = last_rd;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h0; PWDATA = 32'h0;
    ev_valid = 1'b0;
    src_q.delete();
    #2;
    check("rst_ready", 32'(ev_ready), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int          op;
    #1;
    do_reset();
    apb(1'b0, 12'h008, 32'h0, 9'h0, r);
    check("ctrl_reset", r, 32'h0000_0101);

    // three IDs, one per cycle, then pop them back
    send(8'h05); send(8'h11); send(8'h21);
    wait_src_empty(10);
    apb(1'b0, 12'h004, 32'h0, 9'h0, r);
    check("status_cnt3", r, 32'h0000_0300);
    apb(1'b0, 12'h000, 32'h0, 9'h0, r); check("pop1", r, 32'h8003_0005);
    apb(1'b0, 12'h000, 32'h0, 9'h0, r); check("pop2", r, 32'h8002_0011);
    apb(1'b0, 12'h000, 32'h0, 9'h0, r); check("pop3", r, 32'h8001_0021);
    apb(1'b0, 12'h000, 32'h0, 9'h0, r); check("pop_empty", r, 32'h0);

    // nine events into a depth-8 FIFO with valid held
    for (int i = 0; i < 9; i++) send(8'h40 + 8'(i));
    for (int n = 0; n < 20 && q.size() < DEPTH; n++) tick();
    check("full_ready", 32'(ev_ready), 32'h0);
    tick();
    apb(1'b0, 12'h000, 32'h0, 9'h0, r);
    check("full_pop", r, 32'h8008_0040);
    wait_src_empty(5);
    for (int i = 0; i < DEPTH; i++) apb(1'b0, 12'h000, 32'h0, 9'h0, r);
    check("ninth_last", r, 32'h8001_0048);
    apb(1'b0, 12'h010, 32'h0, 9'h0, r);
    check("drop_zero", r, 32'h0);

    // disabled: events are sunk and counted
    apb(1'b1, 12'h008, 32'h0000_0300, 9'h0, r);
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
    wait_src_empty(10);
    apb(1'b0, 12'h004, 32'h0, 9'h0, r); check("dis_status", r, 32'h0000_0001);
    apb(1'b0, 12'h010, 32'h0, 9'h0, r); check("drop_four", r, 32'h0000_0004);
    apb(1'b1, 12'h010, 32'h0, 9'h0, r);
    apb(1'b0, 12'h010, 32'h0, 9'h0, r); check("drop_clr", r, 32'h0);

    // threshold interrupt
    apb(1'b1, 12'h008, 32'h0000_0303, 9'h0, r);
    send(8'h60); send(8'h61); send(8'h62);
    wait_src_empty(10);
    check("irq_hi", 32'(irq), 32'h1);
    apb(1'b0, 12'h000, 32'h0, 9'h0, r);
    check("irq_lo", 32'(irq), 32'h0);

    // simultaneous push and pop around the wrap
    for (int i = 0; i < 20; i++) begin
      apb(1'b0, 12'h000, 32'h0, {1'b1, 8'h2A + 8'(i)}, r);
      check("pp_count", 32'(r[23:16]), 32'h2);
    end
    apb(1'b0, 12'h004, 32'h0, 9'h0, r); check("pp_status", r, 32'h0000_0200);

    // flush racing a push, then an unmapped access
    apb(1'b1, 12'h00C, 32'h1, {1'b1, 8'h77}, r);
    apb(1'b0, 12'h004, 32'h0, 9'h0, r); check("flush_status", r, 32'h0000_0001);
    apb(1'b0, 12'h010, 32'h0, 9'h0, r); check("flush_drop", r, 32'h0000_0001);
    apb(1'b0, 12'h018, 32'h0, 9'h0, r);
    check("unmapped_err", 32'(last_slverr), 32'h1);
    check("unmapped_rd", r, 32'h0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (src_q.size() == 0 && $urandom_range(0, 1) == 1) send(8'($urandom));
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: apb(1'b0, 12'h000, 32'h0, 9'h0, r);
        3: apb(1'b0, 12'h004, 32'h0, 9'h0, r);
        4: apb(1'b0, 12'h008, 32'h0, 9'h0, r);
        5: apb(1'b1, 12'h008, {16'h0, 8'($urandom_range(0, 10)), 6'b0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)}, 9'h0, r);
        6: apb(1'b1, 12'h00C, 32'($urandom_range(0, 1)), 9'h0, r);
        7: apb(1'($urandom_range(0, 1)), 12'h010, $urandom, 9'h0, r);
        8: apb(1'($urandom_range(0, 1)), 12'h014 + 12'(4 * $urandom_range(0, 2)), $urandom, 9'h0, r);
        default: tick();
      endcase
    end

    // asynchronous reset with events buffered
    apb(1'b1, 12'h008, 32'h0000_0101, 9'h0, r);
    apb(1'b1, 12'h00C, 32'h1, 9'h0, r);
    wait_src_empty(20);
    send(8'hA1); send(8'hA2); send(8'hA3);
    wait_src_empty(10);
    do_reset();
    apb(1'b0, 12'h004, 32'h0, 9'h0, r); check("post_rst_status", r, 32'h0000_0001);
    apb(1'b0, 12'h008, 32'h0, 9'h0, r); check("post_rst_ctrl", r, 32'h0000_0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
